// File: rtl/bus_demux2_if.sv
// bus_demux2_if: upstream request/response bus plus the two downstream target ports of bus_demux2.
interface bus_demux2_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_we;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  zero_req_valid;
    logic                  zero_req_ready;
    logic [ADDR_WIDTH-1:0] zero_req_addr;
    logic [DATA_WIDTH-1:0] zero_req_wdata;
    logic                  zero_req_we;
    logic                  zero_rsp_valid;
    logic [DATA_WIDTH-1:0] zero_rsp_rdata;
    logic                  one_req_valid;
    logic                  one_req_ready;
    logic [ADDR_WIDTH-1:0] one_req_addr;
    logic [DATA_WIDTH-1:0] one_req_wdata;
    logic                  one_req_we;
    logic                  one_rsp_valid;
    logic [DATA_WIDTH-1:0] one_rsp_rdata;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output zero_req_valid, zero_req_addr, zero_req_wdata, zero_req_we,
        input  zero_req_ready, zero_rsp_valid, zero_rsp_rdata,
        output one_req_valid, one_req_addr, one_req_wdata, one_req_we,
        input  one_req_ready, one_rsp_valid, one_rsp_rdata
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_we,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  zero_req_valid, zero_req_addr, zero_req_wdata, zero_req_we,
        output zero_req_ready, zero_rsp_valid, zero_rsp_rdata,
        input  one_req_valid, one_req_addr, one_req_wdata, one_req_we,
        output one_req_ready, one_rsp_valid, one_rsp_rdata
    );
endinterface

// File: rtl/bus_demux2.sv
// bus_demux2: registered 1-to-2 request router with in-order response merge.
// In-flight requests are confined to one target so responses need no tags.
module bus_demux2 #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] SEL_BASE   = 'h1100_0000,
    parameter logic [ADDR_WIDTH-1:0] SEL_MASK   = 'hFF00_0000,
    parameter int                    MAX_OUT    = 2
) (
    input logic         clk,
    input logic         rst_n,
    bus_demux2_if.slave bus
);
    localparam logic [3:0] MAX_CNT = 4'(MAX_OUT);

    logic                  hold_valid;
    logic                  hold_tgt;
    logic [ADDR_WIDTH-1:0] hold_addr;
    logic [DATA_WIDTH-1:0] hold_wdata;
    logic                  hold_we;
    logic [3:0]            out_cnt;
    logic                  cur_tgt;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  issue_ok;
    logic                  fire;
    logic                  req_ready;
    logic                  acc_zero;
    logic                  acc_one;
    logic                  spurious;

    always_comb begin
        issue_ok  = hold_valid && out_cnt < MAX_CNT && (out_cnt == 4'd0 || cur_tgt == hold_tgt);
        fire      = issue_ok && (hold_tgt ? bus.one_req_ready : bus.zero_req_ready);
        req_ready = !hold_valid || fire;
        acc_zero  = bus.zero_rsp_valid && out_cnt != 4'd0 && !cur_tgt;
        acc_one   = bus.one_rsp_valid && out_cnt != 4'd0 && cur_tgt;
        spurious  = (bus.zero_rsp_valid && !acc_zero) || (bus.one_rsp_valid && !acc_one);
    end

    assign bus.req_ready      = req_ready;
    assign bus.zero_req_valid = issue_ok && !hold_tgt;
    assign bus.one_req_valid  = issue_ok && hold_tgt;
    assign bus.zero_req_addr  = hold_addr;
    assign bus.zero_req_wdata = hold_wdata;
    assign bus.zero_req_we    = hold_we;
    assign bus.one_req_addr   = hold_addr;
    assign bus.one_req_wdata  = hold_wdata;
    assign bus.one_req_we     = hold_we;
    assign bus.rsp_valid      = rsp_valid;
    assign bus.rsp_rdata      = rsp_rdata;
    assign bus.rsp_err        = rsp_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_tgt   <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_we    <= 1'b0;
            out_cnt    <= 4'd0;
            cur_tgt    <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (bus.req_valid && req_ready) begin
                hold_valid <= 1'b1;
                hold_tgt   <= (bus.req_addr & SEL_MASK) == SEL_BASE;
                hold_addr  <= bus.req_addr;
                hold_wdata <= bus.req_wdata;
                hold_we    <= bus.req_we;
            end else if (fire) begin
                hold_valid <= 1'b0;
            end
            out_cnt <= out_cnt + 4'(fire) - 4'(acc_zero || acc_one);
            if (fire) cur_tgt <= hold_tgt;
            rsp_valid <= acc_zero || acc_one;
            if (acc_zero || acc_one) rsp_rdata <= acc_one ? bus.one_rsp_rdata : bus.zero_rsp_rdata;
            if (spurious) rsp_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bus_demux2.sv
// tb_bus_demux2: directed scenario bench for bus_demux2 with hand-computed expectations.
module tb_bus_demux2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    bus_demux2_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
    bus_demux2 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_we = 1'b0;
        bus.zero_req_ready = 1'b1;
        bus.zero_rsp_valid = 1'b0;
        bus.zero_rsp_rdata = 32'h0;
        bus.one_req_ready = 1'b1;
        bus.one_rsp_valid = 1'b0;
        bus.one_rsp_rdata = 32'h0;
    endtask

    task automatic drive_req(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_addr = addr;
        bus.req_we = we;
        bus.req_wdata = wdata;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
        n_cmp++; if ({bus.zero_req_valid, bus.one_req_valid} !== 2'b00) begin n_err++; $display("FAIL reset_req_valid got %b want 00", {bus.zero_req_valid, bus.one_req_valid}); end
        n_cmp++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b00) begin n_err++; $display("FAIL reset_rsp got %b want 00", {bus.rsp_valid, bus.rsp_err}); end
        n_cmp++; if (bus.rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", bus.rsp_rdata); end
        n_cmp++; if (bus.zero_req_addr !== 32'h0 || bus.one_req_wdata !== 32'h0) begin n_err++; $display("FAIL reset_payload got %h/%h want 0", bus.zero_req_addr, bus.one_req_wdata); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        drive_req(32'h0000_0100, 1'b0, 32'h0);
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL rd_ready got %b want 1", bus.req_ready); end
        step();
        bus.req_valid = 1'b0;
        #1;
        n_cmp++; if (bus.zero_req_valid !== 1'b1 || bus.one_req_valid !== 1'b0) begin n_err++; $display("FAIL rd_issue got z=%b o=%b want z=1 o=0", bus.zero_req_valid, bus.one_req_valid); end
        n_cmp++; if (bus.zero_req_addr !== 32'h100 || bus.zero_req_we !== 1'b0) begin n_err++; $display("FAIL rd_payload got %h we=%b want 00000100 we=0", bus.zero_req_addr, bus.zero_req_we); end
        step();
        bus.zero_rsp_valid = 1'b1;
        bus.zero_rsp_rdata = 32'hDEAD_BEEF;
        #1;
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.one_req_valid !== 1'b0) begin n_err++; $display("FAIL rd_no_comb got rsp=%b one=%b want 0 0", bus.rsp_valid, bus.one_req_valid); end
        step();
        bus.zero_rsp_valid = 1'b0;
        #1;
        n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL rd_rsp got v=%b %h want v=1 deadbeef", bus.rsp_valid, bus.rsp_rdata); end
        step();
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL rd_rsp_end got v=%b err=%b want 0 0", bus.rsp_valid, bus.rsp_err); end
    endtask

    task automatic test_mmio_write();
        int rsp_cnt = 0;
        drive_req(32'h1100_0040, 1'b1, 32'h55);
        #1;
        step();
        bus.req_valid = 1'b0;
        #1;
        n_cmp++; if (bus.one_req_valid !== 1'b1 || bus.zero_req_valid !== 1'b0) begin n_err++; $display("FAIL wr_decode got o=%b z=%b want o=1 z=0", bus.one_req_valid, bus.zero_req_valid); end
        n_cmp++; if (bus.one_req_we !== 1'b1 || bus.one_req_wdata !== 32'h55) begin n_err++; $display("FAIL wr_payload got we=%b %h want we=1 00000055", bus.one_req_we, bus.one_req_wdata); end
        step();
        bus.one_rsp_valid = 1'b1;
        #1;
        step();
        bus.one_rsp_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (bus.rsp_valid === 1'b1) rsp_cnt++;
            step();
        end
        n_cmp++; if (rsp_cnt !== 1) begin n_err++; $display("FAIL wr_rsp_count got %0d want 1", rsp_cnt); end
    endtask

    task automatic test_pipeline();
        drive_req(32'h10, 1'b0, 32'h0);
        #1;
        step();
        drive_req(32'h20, 1'b0, 32'h0);
        #1;
        n_cmp++; if (bus.req_ready !== 1'b1 || bus.zero_req_valid !== 1'b1) begin n_err++; $display("FAIL pipe_first got rdy=%b v=%b want 1 1", bus.req_ready, bus.zero_req_valid); end
        step();
        drive_req(32'h30, 1'b0, 32'h0);
        #1;
        n_cmp++; if (bus.zero_req_valid !== 1'b1 || bus.zero_req_addr !== 32'h20) begin n_err++; $display("FAIL pipe_second got v=%b %h want 1 00000020", bus.zero_req_valid, bus.zero_req_addr); end
        step();
        bus.req_valid = 1'b0;
        #1;
        n_cmp++; if (bus.zero_req_valid !== 1'b0 || bus.req_ready !== 1'b0) begin n_err++; $display("FAIL pipe_block got v=%b rdy=%b want 0 0", bus.zero_req_valid, bus.req_ready); end
        step();
        bus.zero_rsp_valid = 1'b1;
        bus.zero_rsp_rdata = 32'hA1;
        #1;
        n_cmp++; if (bus.zero_req_valid !== 1'b0) begin n_err++; $display("FAIL pipe_same_cycle got v=%b want 0", bus.zero_req_valid); end
        step();
        bus.zero_rsp_valid = 1'b0;
        #1;
        n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hA1) begin n_err++; $display("FAIL pipe_rsp1 got v=%b %h want 1 000000a1", bus.rsp_valid, bus.rsp_rdata); end
        n_cmp++; if (bus.zero_req_valid !== 1'b1 || bus.zero_req_addr !== 32'h30) begin n_err++; $display("FAIL pipe_third got v=%b %h want 1 00000030", bus.zero_req_valid, bus.zero_req_addr); end
        step();
        bus.zero_rsp_valid = 1'b1;
        bus.zero_rsp_rdata = 32'hB2;
        #1;
        step();
        bus.zero_rsp_rdata = 32'hC3;
        #1;
        n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hB2) begin n_err++; $display("FAIL pipe_rsp2 got v=%b %h want 1 000000b2", bus.rsp_valid, bus.rsp_rdata); end
        step();
        bus.zero_rsp_valid = 1'b0;
        #1;
        n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hC3) begin n_err++; $display("FAIL pipe_rsp3 got v=%b %h want 1 000000c3", bus.rsp_valid, bus.rsp_rdata); end
        step();
    endtask

    task automatic test_switch();
        drive_req(32'h200, 1'b0, 32'h0);
        #1;
        step();
        drive_req(32'h1100_0000, 1'b0, 32'h0);
        #1;
        step();
        bus.req_valid = 1'b0;
        #1;
        n_cmp++; if (bus.one_req_valid !== 1'b0) begin n_err++; $display("FAIL sw_wait1 got %b want 0", bus.one_req_valid); end
        step();
        bus.zero_rsp_valid = 1'b1;
        bus.zero_rsp_rdata = 32'h77;
        #1;
        n_cmp++; if (bus.one_req_valid !== 1'b0) begin n_err++; $display("FAIL sw_wait2 got %b want 0", bus.one_req_valid); end
        step();
        bus.zero_rsp_valid = 1'b0;
        #1;
        n_cmp++; if (bus.one_req_valid !== 1'b1 || bus.one_req_addr !== 32'h1100_0000) begin n_err++; $display("FAIL sw_issue got v=%b %h want 1 11000000", bus.one_req_valid, bus.one_req_addr); end
        n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h77) begin n_err++; $display("FAIL sw_rsp0 got v=%b %h want 1 00000077", bus.rsp_valid, bus.rsp_rdata); end
        step();
        bus.one_rsp_valid = 1'b1;
        bus.one_rsp_rdata = 32'h88;
        #1;
        step();
        bus.one_rsp_valid = 1'b0;
        #1;
        n_cmp++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h88 || bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL sw_rsp1 got v=%b %h err=%b want 1 00000088 0", bus.rsp_valid, bus.rsp_rdata, bus.rsp_err); end
        step();
    endtask

    task automatic test_stall();
        logic stable = 1'b1;
        bus.one_req_ready = 1'b0;
        drive_req(32'h1100_0080, 1'b1, 32'h1234);
        #1;
        step();
        bus.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.one_req_valid !== 1'b1 || bus.req_ready !== 1'b0 || bus.one_req_addr !== 32'h1100_0080 || bus.one_req_wdata !== 32'h1234 || bus.one_req_we !== 1'b1) stable = 1'b0;
            step();
        end
        n_cmp++; if (stable !== 1'b1) begin n_err++; $display("FAIL stall_hold got stable=%b want 1", stable); end
        bus.one_req_ready = 1'b1;
        #1;
        n_cmp++; if (bus.one_req_valid !== 1'b1 || bus.req_ready !== 1'b1) begin n_err++; $display("FAIL stall_release got v=%b rdy=%b want 1 1", bus.one_req_valid, bus.req_ready); end
        step();
        n_cmp++; if (bus.one_req_valid !== 1'b0) begin n_err++; $display("FAIL stall_single got v=%b want 0", bus.one_req_valid); end
        bus.one_rsp_valid = 1'b1;
        #1;
        step();
        bus.one_rsp_valid = 1'b0;
        #1;
        n_cmp++; if (bus.rsp_valid !== 1'b1) begin n_err++; $display("FAIL stall_rsp got %b want 1", bus.rsp_valid); end
        step();
    endtask

    task automatic test_spurious();
        bus.one_rsp_valid = 1'b1;
        bus.one_rsp_rdata = 32'h99;
        #1;
        step();
        bus.one_rsp_valid = 1'b0;
        #1;
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b1) begin n_err++; $display("FAIL spur_idle got v=%b err=%b want 0 1", bus.rsp_valid, bus.rsp_err); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL spur_clear1 got %b want 0", bus.rsp_err); end
        drive_req(32'h300, 1'b0, 32'h0);
        #1;
        step();
        bus.req_valid = 1'b0;
        #1;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.zero_req_valid !== 1'b0 || bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL spur_midreset got v=%b err=%b want 0 0", bus.zero_req_valid, bus.rsp_err); end
        bus.zero_rsp_valid = 1'b1;
        bus.zero_rsp_rdata = 32'h5A;
        #1;
        step();
        bus.zero_rsp_valid = 1'b0;
        #1;
        n_cmp++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b1) begin n_err++; $display("FAIL spur_late got v=%b err=%b want 0 1", bus.rsp_valid, bus.rsp_err); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        n_cmp++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL spur_clear2 got %b want 0", bus.rsp_err); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_mmio_write();
        test_pipeline();
        test_switch();
        test_stall();
        test_spurious();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
